// File: rtl/edge_dependant_pkg.sv
// Shared shadow-state definitions for the edge-dependent line code.
// The encoder and decoder both import this so one transition table serves both ends.
package edge_dependant_pkg;

   typedef enum logic [1:0] {
      ST_A = 2'b00,
      ST_B = 2'b01,
      ST_C = 2'b10,
      ST_D = 2'b11
   } state_e;

   // Only D passes the line bit straight through; A/B/C invert it.
   function automatic logic decode(input state_e s, input logic line_bit);
      return line_bit ^ (s != ST_D);
   endfunction

   function automatic state_e next_state(input state_e s, input logic d);
      state_e ns;
      unique case (s)
         ST_A:    ns = d ? ST_A : ST_D;
         ST_B:    ns = d ? ST_A : ST_C;
         ST_C:    ns = d ? ST_B : ST_D;
         default: ns = d ? ST_D : ST_C;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/edge_dependant_shadow_fsm.sv
// Shadow copy of the encoder state machine: recovers each input bit from the line bit.
// dec_now_o is the same-cycle decoded bit used by the deserializer; dec_bit_o is its registered copy.
module edge_dependant_shadow_fsm
   import edge_dependant_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic resync_i,
   input  logic enc_valid_i,
   input  logic enc_bit_i,
   output logic take_o,
   output logic dec_now_o,
   output logic dec_bit_o,
   output logic dec_bit_valid_o
);

   state_e state_q, state_d;
   logic   dec_q, dec_d;
   logic   dv_q;

   assign take_o    = enc_valid_i && !resync_i;
   assign dec_now_o = decode(state_q, enc_bit_i);

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      if (resync_i) begin
         state_d = ST_A;
      end else if (enc_valid_i) begin
         state_d = next_state(state_q, dec_now_o);
         dec_d   = dec_now_o;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_A;
         dec_q   <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         dv_q    <= take_o;
      end
   end

   assign dec_bit_o       = dec_q;
   assign dec_bit_valid_o = dv_q;

endmodule

// File: rtl/edge_dependant_decoder.sv
// Edge-dependent line decoder: shadow FSM followed by a WIDTH-bit deserializer
// with a single-entry valid/ready output slot and a sticky overrun flag.
module edge_dependant_decoder
   import edge_dependant_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             resync,
   input  logic             enc_valid,
   input  logic             enc_bit,
   output logic             dec_bit,
   output logic             dec_bit_valid,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overrun
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic take, dec_now;

   edge_dependant_shadow_fsm u_fsm (
      .clk             (clk),
      .rst             (rst),
      .resync_i        (resync),
      .enc_valid_i     (enc_valid),
      .enc_bit_i       (enc_bit),
      .take_o          (take),
      .dec_now_o       (dec_now),
      .dec_bit_o       (dec_bit),
      .dec_bit_valid_o (dec_bit_valid)
   );

   logic [WIDTH-1:0] shift_q, shift_d, shift_nx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             wvalid_q, wvalid_d;
   logic             ovr_q, ovr_d;
   logic             complete, slot_free;

   always_comb begin
      // LSB-first shifts in at the top so the first bit ends up in bit 0.
      if (LSB_FIRST) shift_nx = {dec_now, shift_q[WIDTH-1:1]};
      else           shift_nx = {shift_q[WIDTH-2:0], dec_now};

      complete  = take && (cnt_q == CNT_LAST);
      slot_free = !wvalid_q || word_ready;

      shift_d  = shift_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      wvalid_d = wvalid_q;
      ovr_d    = ovr_q;

      if (resync) begin
         cnt_d = '0;
      end else if (take) begin
         shift_d = shift_nx;
         cnt_d   = complete ? '0 : cnt_q + 1'b1;
      end

      if (wvalid_q && word_ready) wvalid_d = 1'b0;
      if (complete) begin
         if (slot_free) begin
            word_d   = shift_nx;
            wvalid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shift_q  <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         wvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         wvalid_q <= wvalid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign word_out   = word_q;
   assign word_valid = wvalid_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_edge_dependant_decoder.sv
// Randomized self-checking bench: a behavioural line encoder produces symbols from
// known data bits; the reference expects those bits back and models the word slot.
module tb_edge_dependant_decoder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         resync = 1'b0;
   logic         enc_valid = 1'b0;
   logic         enc_bit = 1'b0;
   logic         dec_bit, dec_bit_valid;
   logic [W-1:0] word_out;
   logic         word_valid;
   logic         word_ready = 1'b0;
   logic         overrun;

   int checks = 0;
   int errors = 0;

   edge_dependant_decoder #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .resync        (resync),
      .enc_valid     (enc_valid),
      .enc_bit       (enc_bit),
      .dec_bit       (dec_bit),
      .dec_bit_valid (dec_bit_valid),
      .word_out      (word_out),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Reference: encoder state (0=A,1=B,2=C,3=D), collected bits, word slot.
   int         enc_st;
   int         nbits;
   int         acc;
   logic       m_dv, m_db, m_wv, m_ovr;
   logic [W-1:0] m_word;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Encoder rule: line = bit, inverted unless in D; transitions follow the data bit.
   function automatic logic encode(input logic b);
      logic line;
      line = (enc_st == 3) ? b : ~b;
      case (enc_st)
         0: enc_st = b ? 0 : 3;
         1: enc_st = b ? 0 : 2;
         2: enc_st = b ? 1 : 3;
         default: enc_st = b ? 3 : 2;
      endcase
      return line;
   endfunction

   task automatic check_outputs();
      chk("dec_bit_valid", 32'(dec_bit_valid), 32'(m_dv));
      if (m_dv) chk("dec_bit", 32'(dec_bit), 32'(m_db));
      chk("word_valid", 32'(word_valid), 32'(m_wv));
      if (m_wv) chk("word_out", 32'(word_out), 32'(m_word));
      chk("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   task automatic model_reset();
      enc_st = 0; nbits = 0; acc = 0;
      m_dv = 0; m_db = 0; m_wv = 0; m_ovr = 0; m_word = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0; enc_valid = 1'b0; resync = 1'b0; word_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      chk("rst_dec_bit", 32'(dec_bit), 32'd0);
      chk("rst_word_out", 32'(word_out), 32'd0);
      check_outputs();
      rst = 1'b1;
   endtask

   // One clock: optionally send data bit b (encoded), optionally resync, with given ready.
   task automatic step(input logic v, input logic b, input logic rs, input logic rdy);
      logic done;
      logic [W-1:0] nw;
      done = 1'b0;
      nw = '0;
      enc_valid  = v;
      resync     = rs;
      word_ready = rdy;
      m_dv = 1'b0;
      if (rs) begin
         enc_bit = $urandom_range(0, 1);
         enc_st = 0; nbits = 0; acc = 0;
      end else if (v) begin
         enc_bit = encode(b);
         m_dv = 1'b1;
         m_db = b;
         acc = acc | (int'(b) << nbits);
         nbits++;
         if (nbits == W) begin
            done = 1'b1;
            nw = W'(acc);
            nbits = 0; acc = 0;
         end
      end else begin
         enc_bit = $urandom_range(0, 1);
      end
      if (done && (!m_wv || rdy)) begin
         m_word = nw; m_wv = 1'b1;
      end else if (done) begin
         m_ovr = 1'b1;
      end else if (m_wv && rdy) begin
         m_wv = 1'b0;
      end
      @(posedge clk); #1;
      check_outputs();
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic last_rdy);
      for (int i = 0; i < W; i++)
         step(1'b1, w[i], 1'b0, (i == W - 1) ? last_rdy : rdy);
   endtask

   initial begin
      logic [5:0] seq_bits;
      int         seq_st [6];
      seq_bits = 6'b011001;            // bits 1,0,0,1,1,0 in index order 0..5
      seq_st   = '{0, 3, 2, 1, 0, 3};  // shadow states A,D,C,B,A,D

      @(posedge clk); #1;
      do_reset();

      // Decode sequence with shadow state tracking
      for (int i = 0; i < 6; i++) begin
         step(1'b1, seq_bits[i], 1'b0, 1'b1);
         chk("shadow_state", 32'(dut.u_fsm.state_q), 32'(seq_st[i]));
      end

      // Single word 0xA5
      do_reset();
      send_word(8'hA5, 1'b1, 1'b1);
      chk("word_a5", 32'(word_out), 32'hA5);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Backpressure: second word dropped
      do_reset();
      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      chk("bp_hold", 32'(word_out), 32'h3C);
      chk("bp_ovr", 32'(overrun), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("bp_drop", 32'(word_valid), 32'd0);

      // Handshake coincides with completion
      do_reset();
      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b1);
      chk("coin_word", 32'(word_out), 32'hC3);
      chk("coin_vld", 32'(word_valid), 32'd1);
      chk("coin_ovr", 32'(overrun), 32'd0);

      // Resync mid-word, resync cycle carries enc_valid=1
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      send_word(8'h5E, 1'b1, 1'b1);
      chk("resync_word", 32'(word_out), 32'h5E);

      // Reset with a held word and a partial word in flight
      do_reset();
      send_word(8'h81, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      do_reset();
      send_word(8'h69, 1'b1, 1'b1);

      // Randomized traffic with gaps, backpressure and occasional resync
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_dependant_decoder.md
# edge_dependant_decoder

Receive-side counterpart of the edge-dependent line encoder. It takes the encoder's serial output stream and regenerates the original input bits by running a shadow copy of the encoder's 4-state machine. It then packs the recovered bits into WIDTH-bit words with a valid/ready handshake. It sits directly after the encoded line (or its sampler) and feeds a word-oriented consumer.

## Interface
- WIDTH, 8: bits per assembled word (2..32).
- LSB_FIRST, 1: 1 = first recovered bit lands in word bit 0; 0 = first bit lands in bit WIDTH-1.
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  reset, synchronous, active-low.
- resync  in  1  sync clear of shadow state and bit counter; held word and overrun untouched.
- enc_valid  in  1  enc_bit is a new encoded symbol this cycle.
- enc_bit  in  1  encoded line bit.
- dec_bit  out  1  recovered bit, registered.
- dec_bit_valid  out  1  one-cycle strobe qualifying dec_bit.
- word_out  out  WIDTH  assembled word, stable while word_valid.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
- overrun  out  1  sticky: a completed word was dropped.

## Operation
- Shadow states: A=00, B=01, C=10, D=11. Reset and resync both set the state to A, which matches the encoder's reset state.
- Decode rule: dec = enc_bit XOR (state != D). In A, B and C a line 0 means input 1. In D the line bit equals the input bit.
- Next state, from the decoded bit d:
  - A: d=1 → A; d=0 → D.
  - B: d=1 → A; d=0 → C.
  - C: d=1 → B; d=0 → D.
  - D: d=1 → D; d=0 → C.
- State, dec_bit and the shift register update only when enc_valid=1. Otherwise everything holds and dec_bit_valid=0.
- Deserializer:
  - The recovered bit shifts into a WIDTH-bit shift register according to LSB_FIRST.
  - A bit counter runs 0..WIDTH-1 and wraps to 0 on the WIDTH-th bit. That bit completes a word.
- Output register:
  - On completion, the full word (including the completing bit) loads into word_out if the slot is free, i.e. word_valid=0, or word_valid && word_ready in the same cycle.
  - Otherwise the new word is discarded, word_out keeps the old word, and overrun is set to 1.
- word_valid rises with the load. It clears on handshake unless a new word loads in that same cycle, in which case it stays 1.
- overrun clears only on rst.
- resync takes priority over enc_valid in the same cycle: the symbol is ignored, and no dec_bit_valid or completion occurs.

## Timing
- Reset values (cycle after rst=0 sampled at clk): state=A, bit counter=0, shift register=0, dec_bit=0, dec_bit_valid=0, word_out=0, word_valid=0, overrun=0.
- Reset mid-word discards any partial word and any held word.
- Latency: enc_valid at edge n gives dec_bit / dec_bit_valid after edge n, with no combinational path from input to output.
- The completing symbol at edge n gives word_out / word_valid after edge n, in the same cycle as its dec_bit_valid.
- Throughput: one symbol per clock. Back-to-back words are sustained when word_ready is held high.
- word_out must not change while word_valid=1 and word_ready=0.

## Structure
- Shared package (edge_dependant_pkg):
  - state typedef (A/B/C/D encodings);
  - decode function;
  - next-state function.
- The encoder's build reuses this package so both ends share one transition table.
- One sub-module, edge_dependant_shadow_fsm: state register plus the decode and next-state logic.
- The top level holds the deserializer, output register and overrun logic.

## Test plan
- Decode sequence: after reset, encoded symbols 0,1,0,0,0,1 with enc_valid=1 each cycle → dec_bit 1,0,0,1,1,0, and shadow state A,D,C,B,A,D after each symbol.
- Word assembly: feed the golden-model encoding of input bits 1,0,1,0,0,1,0,1 (WIDTH=8, LSB_FIRST=1) with word_ready=1 → one word_valid pulse, word_out=0xA5, overrun=0.
- Backpressure: two consecutive words 0x3C then 0xC3 with word_ready=0 → word_out stays 0x3C, overrun=1 after the 16th symbol. Then word_ready=1 → word_valid drops and overrun stays 1.
- Handshake coincidence: word_ready=1 in the exact cycle the second word completes → word_out switches to the new word, word_valid remains 1, overrun=0.
- resync mid-word: 3 symbols, then resync=1 together with enc_valid=1, then a fresh 8-bit word → no dec_bit_valid in the resync cycle, counter restarts, and the correct word is output.
- Reset mid-operation: rst=0 with word_valid=1 and counter=5 → all outputs at reset values the next cycle. Decoding then restarts from state A.
